// File: rtl/object_feature_reader_pkg.sv
// Shared definitions for the object feature reader: table widths and the
// scan state encoding.
package object_feature_reader_pkg;

    // Label ID width and location/sum width of the labeling block's tables.
    localparam int LBL_WIDTH = 8;
    localparam int LOC_SIZE  = 16;

    // Scan states. OFR_DIV is only reachable when the centroid divider is built.
    typedef enum logic [2:0] {
        OFR_IDLE  = 3'd0,
        OFR_ISSUE = 3'd1,
        OFR_WAIT  = 3'd2,
        OFR_DIV   = 3'd3,
        OFR_EMIT  = 3'd4,
        OFR_FIN   = 3'd5
    } ofr_state_t;

endpackage

// File: rtl/object_feature_reader_serial_divider.sv
// Restoring serial divider, one quotient bit per cycle, LOC_SIZE cycles after
// a one-cycle start. The quotient register holds its result until the next start.
module serial_divider
    import object_feature_reader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [LOC_SIZE-1:0] dividend,
    input  logic [LOC_SIZE-1:0] divisor,
    output logic [LOC_SIZE-1:0] quotient,
    output logic                div_done
);

    localparam int STEP_W = $clog2(LOC_SIZE);

    logic [LOC_SIZE:0]   rem;
    logic [LOC_SIZE-1:0] dvs;
    logic [STEP_W-1:0]   step;
    logic                running;
    logic [LOC_SIZE:0]   shifted;
    logic [LOC_SIZE:0]   trial;

    // Shift the next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        shifted = {rem[LOC_SIZE-1:0], quotient[LOC_SIZE-1]};
        trial   = shifted - {1'b0, dvs};
    end

    // Asserted during the last step so the result is ready on the following cycle.
    assign div_done = running && (step == STEP_W'(LOC_SIZE - 1));

    // Iterate: the quotient register doubles as the dividend shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem      <= '0;
            dvs      <= '0;
            quotient <= '0;
            step     <= '0;
            running  <= 1'b0;
        end else if (start) begin
            rem      <= '0;
            dvs      <= divisor;
            quotient <= dividend;
            step     <= '0;
            running  <= 1'b1;
        end else if (running) begin
            // A clear MSB means the trial subtract did not go negative: restore skipped.
            if (!trial[LOC_SIZE]) begin
                rem      <= trial;
                quotient <= {quotient[LOC_SIZE-2:0], 1'b1};
            end else begin
                rem      <= shifted;
                quotient <= {quotient[LOC_SIZE-2:0], 1'b0};
            end
            step <= step + 1'b1;
            if (div_done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/object_feature_reader.sv
// Post-frame object feature reader: walks label IDs 1..num_labels-1 through the
// table read port, drops small objects and streams one record per survivor.
// Build option: define CENTROID_EN to emit integer centroids (sum/area) via two
// serial dividers; without it out_cx/out_cy carry the raw coordinate sums.
module object_feature_reader
    import object_feature_reader_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int MIN_AREA   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LBL_WIDTH-1:0] num_labels,
    output logic [LBL_WIDTH-1:0] obj_id,
    input  logic [LOC_SIZE-1:0]  obj_area,
    input  logic [LOC_SIZE-1:0]  obj_x,
    input  logic [LOC_SIZE-1:0]  obj_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LBL_WIDTH-1:0] out_id,
    output logic [LOC_SIZE-1:0]  out_area,
    output logic [LOC_SIZE-1:0]  out_cx,
    output logic [LOC_SIZE-1:0]  out_cy,
    output logic                 busy,
    output logic                 done
);

    localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    ofr_state_t           state, state_next;
    logic [LBL_WIDTH-1:0] id;
    logic [LBL_WIDTH-1:0] num_q;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [LOC_SIZE-1:0]  sum_x;
    logic [LOC_SIZE-1:0]  sum_y;
    logic [LBL_WIDTH:0]   id_inc;
    logic                 last_id;
    logic                 too_small;
    logic                 read_ready;
    logic                 advance;

    assign id_inc     = {1'b0, id} + 1'b1;
    assign last_id    = id_inc >= {1'b0, num_q};
    assign too_small  = obj_area < LOC_SIZE'(MIN_AREA);
    assign read_ready = (state == OFR_WAIT) && (wait_cnt == '0);

    // Label 0 is reserved, so the read address idles at 0 outside a scan.
    assign obj_id    = (state == OFR_ISSUE || state == OFR_WAIT ||
                        state == OFR_DIV   || state == OFR_EMIT) ? id : '0;
    assign out_valid = (state == OFR_EMIT);
    assign busy      = (state != OFR_IDLE);
    assign done      = (state == OFR_FIN);

`ifdef CENTROID_EN
    logic div_start;
    logic done_x, done_y;

    // Dividers launch on the cycle the table data is valid, so DIV lasts LOC_SIZE cycles.
    assign div_start = read_ready && !too_small;

    serial_divider u_div_x (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (obj_x),
        .divisor  (obj_area),
        .quotient (out_cx),
        .div_done (done_x)
    );

    serial_divider u_div_y (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (obj_y),
        .divisor  (obj_area),
        .quotient (out_cy),
        .div_done (done_y)
    );
`else
    assign out_cx = sum_x;
    assign out_cy = sum_y;
`endif

    // Next-state selection and the label-advance strobe.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_next = state;
        advance    = 1'b0;
        case (state)
            OFR_IDLE:
                if (start) begin
                    state_next = (num_labels <= LBL_WIDTH'(1)) ? OFR_FIN : OFR_ISSUE;
                end
            OFR_ISSUE:
                state_next = OFR_WAIT;
            OFR_WAIT:
                if (wait_cnt == '0) begin
                    if (too_small) begin
                        state_next = last_id ? OFR_FIN : OFR_ISSUE;
                        advance    = !last_id;
                    end else begin
`ifdef CENTROID_EN
                        state_next = OFR_DIV;
`else
                        state_next = OFR_EMIT;
`endif
                    end
                end
`ifdef CENTROID_EN
            OFR_DIV:
                if (done_x && done_y) begin
                    state_next = OFR_EMIT;
                end
`endif
            OFR_EMIT:
                if (out_ready) begin
                    state_next = last_id ? OFR_FIN : OFR_ISSUE;
                    advance    = !last_id;
                end
            OFR_FIN:
                state_next = OFR_IDLE;
            default:
                state_next = OFR_IDLE;
        endcase
    end

    // State register plus label counter, read-latency timer and record payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= OFR_IDLE;
            id       <= '0;
            num_q    <= '0;
            wait_cnt <= '0;
            out_id   <= '0;
            out_area <= '0;
            sum_x    <= '0;
            sum_y    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            state <= state_next;
            if (state == OFR_IDLE && start) begin
                id    <= LBL_WIDTH'(1);
                num_q <= num_labels;
            end else if (advance) begin
                id <= id_inc[LBL_WIDTH-1:0];
            end
            if (state == OFR_ISSUE) begin
                wait_cnt <= WAIT_W'(RD_LATENCY - 1);
            end else if (state == OFR_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            // Payload only changes on a kept object, so it is stable throughout EMIT.
            if (read_ready && !too_small) begin
                out_id   <= id;
                out_area <= obj_area;
                sum_x    <= obj_x;
                sum_y    <= obj_y;
            end
        end
    end

endmodule

// File: tb/tb_object_feature_reader.sv
// Self-checking bench for object_feature_reader. A table model answers obj_id
// with RD_LATENCY cycles of latency; expected records and scan length are
// derived from the table contents. Follows CENTROID_EN for expected cx/cy.
module tb_object_feature_reader;
    import object_feature_reader_pkg::*;

    localparam int RD_LAT = 2;
    localparam int MIN_A  = 4;
`ifdef CENTROID_EN
    localparam int DIV_CYC = LOC_SIZE;
`else
    localparam int DIV_CYC = 0;
`endif

    typedef struct {
        int id;
        int area;
        int cx;
        int cy;
    } rec_t;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [LBL_WIDTH-1:0] num_labels;
    logic [LBL_WIDTH-1:0] obj_id;
    logic [LOC_SIZE-1:0]  obj_area, obj_x, obj_y;
    logic                 out_valid;
    logic                 out_ready;
    logic [LBL_WIDTH-1:0] out_id;
    logic [LOC_SIZE-1:0]  out_area, out_cx, out_cy;
    logic                 busy, done;

    int vectors    = 0;
    int miscompares = 0;

    logic [LOC_SIZE-1:0]  tab_area [256];
    logic [LOC_SIZE-1:0]  tab_x    [256];
    logic [LOC_SIZE-1:0]  tab_y    [256];
    logic [LBL_WIDTH-1:0] id_pipe  [RD_LAT];
    rec_t                 exp_q[$];

    object_feature_reader #(.RD_LATENCY(RD_LAT), .MIN_AREA(MIN_A)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_labels (num_labels),
        .obj_id     (obj_id),
        .obj_area   (obj_area),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_area   (out_area),
        .out_cx     (out_cx),
        .out_cy     (out_cy),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table read model: data for an address appears RD_LAT cycles after it is driven.
    always @(posedge clk) begin
        id_pipe[0] <= obj_id;
        for (int i = 1; i < RD_LAT; i++) id_pipe[i] <= id_pipe[i-1];
    end
    assign obj_area = tab_area[id_pipe[RD_LAT-1]];
    assign obj_x    = tab_x[id_pipe[RD_LAT-1]];
    assign obj_y    = tab_y[id_pipe[RD_LAT-1]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected records and the cycle (counted from start) at which done appears, before stalls.
    task automatic build_model(input int n, output int fin_cycle);
        rec_t r;
        exp_q.delete();
        fin_cycle = 1;
        for (int i = 1; i < n; i++) begin
            if (int'(tab_area[i]) >= MIN_A) begin
                r.id   = i;
                r.area = int'(tab_area[i]);
`ifdef CENTROID_EN
                r.cx = int'(tab_x[i]) / int'(tab_area[i]);
                r.cy = int'(tab_y[i]) / int'(tab_area[i]);
`else
                r.cx = int'(tab_x[i]);
                r.cy = int'(tab_y[i]);
`endif
                exp_q.push_back(r);
                fin_cycle += 1 + RD_LAT + DIV_CYC + 1;
            end else begin
                fin_cycle += 1 + RD_LAT;
            end
        end
    endtask

    task automatic set_obj(input int i, input int a, input int sx, input int sy);
        tab_area[i] = LOC_SIZE'(a);
        tab_x[i]    = LOC_SIZE'(sx);
        tab_y[i]    = LOC_SIZE'(sy);
    endtask

    task automatic run_scan(input int n, input int stall_first, input bit rand_ready,
                            input bit inject, input int exp_first_valid);
        int base, stalls, held, first_valid_k;
        bit prev_stall, seen_id, finished, rdy;
        logic [LBL_WIDTH-1:0] p_id, p_obj;
        logic [LOC_SIZE-1:0]  p_area, p_cx, p_cy;
        rec_t r;
        build_model(n, base);
        stalls = 0; held = 0; first_valid_k = 0;
        prev_stall = 0; seen_id = 0; finished = 0;
        p_id = '0; p_obj = '0; p_area = '0; p_cx = '0; p_cy = '0;
        @(negedge clk);
        start = 1'b1;
        num_labels = LBL_WIDTH'(n);
        out_ready = 1'b0;
        for (int k = 1; k <= 2000 && !finished; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) num_labels = LBL_WIDTH'($urandom);
            check("busy", 32'(busy), 1);
            if (n <= 1) check("obj_id_idle", 32'(obj_id), 0);
            else if (!seen_id && obj_id != '0) begin
                check("first_id", 32'(obj_id), 1);
                seen_id = 1;
            end
            if (exp_q.size() == 0) check("unexpected_valid", 32'(out_valid), 0);
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_id", 32'(out_id), 32'(p_id));
                check("stall_area", 32'(out_area), 32'(p_area));
                check("stall_cx", 32'(out_cx), 32'(p_cx));
                check("stall_cy", 32'(out_cy), 32'(p_cy));
                check("stall_obj_id", 32'(obj_id), 32'(p_obj));
            end
            if (out_valid && first_valid_k == 0) begin
                first_valid_k = k;
                if (exp_first_valid > 0) check("first_valid_cycle", k, exp_first_valid);
            end
            rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall_first > 0 && out_valid && held < stall_first) begin
                rdy = 1'b0;
                held++;
            end
            out_ready = rdy;
            if (out_valid && rdy && exp_q.size() > 0) begin
                r = exp_q.pop_front();
                check("rec_id", 32'(out_id), r.id);
                check("rec_area", 32'(out_area), r.area);
                check("rec_cx", 32'(out_cx), r.cx);
                check("rec_cy", 32'(out_cy), r.cy);
            end
            prev_stall = out_valid && !rdy;
            if (prev_stall) begin
                stalls++;
                p_id = out_id; p_area = out_area; p_cx = out_cx; p_cy = out_cy; p_obj = obj_id;
            end
            if (done) begin
                check("done_cycle", k, base + stalls);
                check("records_left", exp_q.size(), 0);
                finished = 1;
            end else if (inject && k == 8) begin
                start = 1'b1;
                num_labels = LBL_WIDTH'($urandom);
            end
        end
        check("done_seen", 32'(finished), 1);
        start = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_done", 32'(done), 0);
        check("post_busy", 32'(busy), 0);
        check("post_obj_id", 32'(obj_id), 0);
        check("post_valid", 32'(out_valid), 0);
    endtask

    initial begin
        int n;
        bit reached;
        reset = 1'b1;
        start = 1'b0;
        num_labels = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 256; i++) set_obj(i, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_obj_id", 32'(obj_id), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_out_id", 32'(out_id), 0);
        check("rst_area", 32'(out_area), 0);
        check("rst_cx", 32'(out_cx), 0);
        check("rst_cy", 32'(out_cy), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        reset = 1'b0;
        @(negedge clk);

        // Empty frames.
        run_scan(1, 0, 0, 0, 0);
        run_scan(0, 0, 0, 0, 0);

        // Single object: centroid (3,5).
        set_obj(1, 9, 27, 45);
        run_scan(2, 0, 0, 0, 2 + RD_LAT + DIV_CYC);

        // Area filter around MIN_AREA.
        set_obj(1, 3, 30, 30);
        set_obj(2, 4, 40, 44);
        set_obj(3, 10, 95, 1234);
        run_scan(4, 0, 0, 0, 1 + (1 + RD_LAT) + 1 + RD_LAT + DIV_CYC);

        // Backpressure on the first record.
        set_obj(1, 12, 600, 250);
        set_obj(2, 5, 17, 99);
        run_scan(3, 20, 0, 0, 2 + RD_LAT + DIV_CYC);

        // Truncation: 7/4 -> 1, 11/4 -> 2.
        set_obj(1, 4, 7, 11);
        run_scan(2, 0, 0, 0, 2 + RD_LAT + DIV_CYC);

        // Reset mid-scan while label 2 is in flight.
        for (int i = 1; i < 5; i++) set_obj(i, 20 + i, 1000 * i, 77 * i);
        @(negedge clk);
        start = 1'b1;
        num_labels = LBL_WIDTH'(5);
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        reached = 0;
        for (int k = 0; k < 300 && !reached; k++) begin
            @(negedge clk);
            if (obj_id == LBL_WIDTH'(2)) reached = 1;
        end
        check("reached_id2", 32'(reached), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_obj_id", 32'(obj_id), 0);
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_out_id", 32'(out_id), 0);
        check("mid_rst_area", 32'(out_area), 0);
        check("mid_rst_cx", 32'(out_cx), 0);
        check("mid_rst_cy", 32'(out_cy), 0);
        check("mid_rst_busy", 32'(busy), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rst_done", 32'(done), 0);
        end
        reset = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("after_rst_done", 32'(done), 0);
        run_scan(5, 0, 0, 0, 2 + RD_LAT + DIV_CYC);

        // Randomized frames with random backpressure and ignored mid-scan starts.
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(0, 12);
            for (int i = 1; i < 13; i++)
                set_obj(i, $urandom_range(0, 12), $urandom_range(0, 65535), $urandom_range(0, 65535));
            run_scan(n, 0, 1, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
